// File: rtl/lte_iq_stream_framer_pkg.sv
// Shared types for the I/Q egress framer.
// - INPUT_DATA_BITWIDTH: width of one packed I/Q sample.
// - iq_sample_t: {q, i} packed sample (Q in the upper half).
// - framer_state_t: WAIT_SYNC until the first 10 ms sync, then RUN.
// - fifo_entry_t: buffered sample plus its start-of-frame tag.
package lte_iq_stream_framer_pkg;
  localparam int INPUT_DATA_BITWIDTH = 32;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] i;
  } iq_sample_t;

  typedef enum logic {WAIT_SYNC = 1'b0, RUN = 1'b1} framer_state_t;

  typedef struct packed {
    logic       user;
    iq_sample_t data;
  } fifo_entry_t;
endpackage

// File: rtl/lte_iq_stream_framer_if.sv
// Output sample stream (valid/ready) of the I/Q framer.
// - outValid: outData/outUser hold a sample.
// - outUser:  current sample is the first of a 10 ms frame.
// - outData:  packed I/Q sample.
// - outReady: consumer takes the sample when outValid && outReady.
interface lte_iq_stream_framer_if;
  import lte_iq_stream_framer_pkg::*;

  logic                           outValid;
  logic                           outUser;
  logic [INPUT_DATA_BITWIDTH-1:0] outData;
  logic                           outReady;

  modport master (output outValid, output outUser, output outData, input outReady);
  modport slave  (input outValid, input outUser, input outData, output outReady);
endinterface

// File: rtl/lte_iq_stream_framer_iq_sync_fifo.sv
// Single-clock FIFO with binary pointers carrying one extra wrap bit.
// Read data is the head entry, presented combinationally (show-ahead).
// Ports:
// - clk, rst: clock, asynchronous active-high reset (pointers only).
// - wr_en/wr_data: push; caller must not push when full unless it pops too.
// - rd_en/rd_data: pop / head entry; caller must not pop when empty.
// - full, empty: occupancy flags.
module iq_sync_fifo #(
  parameter int WIDTH  = 33,
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; occupancy comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[ADDR_W-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  // Same slot, different lap => full.
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
endmodule

// File: rtl/lte_iq_stream_framer.sv
// Egress framer: buffers processed I/Q samples, tags the first sample of
// each 10 ms frame, streams them out through a valid/ready register and
// reports per-frame sample counts and FIFO overflow.
// Ports:
// - clk, rst:      clock, asynchronous active-high reset.
// - syncTo10ms:    one-cycle frame-start pulse.
// - inData/inValid: incoming sample, no upstream backpressure.
// - stream:        output stream (outValid/outUser/outData/outReady).
// - overflow:      sticky, a sample was dropped on a full FIFO.
// - frameLen:      samples accepted in the last completed frame.
// - frameLenValid: one-cycle pulse when frameLen updates.
module lte_iq_stream_framer
  import lte_iq_stream_framer_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           syncTo10ms,
  input  logic [INPUT_DATA_BITWIDTH-1:0] inData,
  input  logic                           inValid,
  lte_iq_stream_framer_if.master         stream,
  output logic                           overflow,
  output logic [FRAME_CNT_WIDTH-1:0]     frameLen,
  output logic                           frameLenValid
);
  framer_state_t state, state_nxt;
  logic          accept_cycle;
  logic          wr_req, wr_en, rd_en, load;
  logic          fifo_full, fifo_empty;
  logic          mark_pending;
  fifo_entry_t   wr_entry, rd_entry;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt;

  logic       out_valid, out_user;
  iq_sample_t out_data;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_SYNC;
    else     state <= state_nxt;
  end

  // The sync cycle itself already accepts input, so a sample arriving
  // together with the first sync is kept and tagged.
  always_comb begin
    state_nxt    = state;
    accept_cycle = 1'b0;
    case (state)
      WAIT_SYNC: begin
        accept_cycle = syncTo10ms;
        if (syncTo10ms) state_nxt = RUN;
      end
      RUN: accept_cycle = 1'b1;
    endcase
  end

  // ---------------- FIFO write/read ----------------
  // Output register takes a new entry when empty or being consumed.
  assign load   = !out_valid || stream.outReady;
  assign rd_en  = load && !fifo_empty;
  assign wr_req = inValid && accept_cycle;
  // When full, a same-edge pop frees the slot the push lands in.
  assign wr_en  = wr_req && (!fifo_full || rd_en);

  assign wr_entry = fifo_entry_t'({mark_pending | syncTo10ms, inData});

  iq_sync_fifo #(
    .WIDTH  ($bits(fifo_entry_t)),
    .ADDR_W (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ---------------- tagging / overflow ----------------
  // The mark survives until a sample is actually written, so a dropped
  // tagged sample hands its tag to the next accepted one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mark_pending <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (wr_en)           mark_pending <= 1'b0;
      else if (syncTo10ms) mark_pending <= 1'b1;
      if (wr_req && !wr_en) overflow <= 1'b1;
    end
  end

  // ---------------- frame counter ----------------
  // A sample written in the sync cycle belongs to the new frame. The
  // sync that leaves WAIT_SYNC closes no frame, so it reports nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt     <= '0;
      frameLen      <= '0;
      frameLenValid <= 1'b0;
    end else begin
      frameLenValid <= 1'b0;
      if (syncTo10ms) begin
        if (state == RUN) begin
          frameLen      <= frame_cnt;
          frameLenValid <= 1'b1;
        end
        frame_cnt <= wr_en ? FRAME_CNT_WIDTH'(1) : '0;
      end else if (wr_en && (frame_cnt != '1)) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_user  <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= !fifo_empty;
      if (!fifo_empty) begin
        out_user <= rd_entry.user;
        out_data <= rd_entry.data;
      end
    end
  end

  assign stream.outValid = out_valid;
  assign stream.outUser  = out_user;
  assign stream.outData  = out_data;
endmodule

// File: tb/tb_lte_iq_stream_framer.sv
module tb_lte_iq_stream_framer;
  logic        clk;
  logic        rst;
  logic        syncTo10ms;
  logic        inValid;
  logic [31:0] inData;
  logic        overflow;
  logic [15:0] frameLen;
  logic        frameLenValid;

  int errors = 0;
  int checks = 0;

  lte_iq_stream_framer_if stream_if ();

  lte_iq_stream_framer #(
    .FIFO_DEPTH_LOG2 (4),
    .FRAME_CNT_WIDTH (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .syncTo10ms    (syncTo10ms),
    .inData        (inData),
    .inValid       (inValid),
    .stream        (stream_if),
    .overflow      (overflow),
    .frameLen      (frameLen),
    .frameLenValid (frameLenValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; syncTo10ms = 1'b0; inValid = 1'b0; inData = '0;
    stream_if.outReady = 1'b0;
    tick(); tick();
    checks++;
    if (stream_if.outValid !== 1'b0 || stream_if.outUser !== 1'b0 || stream_if.outData !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: valid=%b user=%b data=%h want 0/0/0", stream_if.outValid, stream_if.outUser, stream_if.outData);
    end
    checks++;
    if (overflow !== 1'b0 || frameLen !== 16'h0 || frameLenValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: ovf=%b len=%0d lenv=%b want 0/0/0", overflow, frameLen, frameLenValid);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_no_sync();
    stream_if.outReady = 1'b1;
    inValid = 1'b1; inData = 32'h0001_0002;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (stream_if.outValid !== 1'b0) begin
        errors++;
        $display("FAIL no_sync_valid[%0d]: got %b want 0", k, stream_if.outValid);
      end
    end
    inValid = 1'b0;
    tick();
    checks++;
    if (stream_if.outValid !== 1'b0) begin
      errors++;
      $display("FAIL no_sync_buffered: got %b want 0", stream_if.outValid);
    end
  endtask

  task automatic test_tagging();
    logic [31:0] s [4];
    s[0] = 32'h1111_2222; s[1] = 32'h3333_4444; s[2] = 32'h5555_6666; s[3] = 32'h7777_8888;
    stream_if.outReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      syncTo10ms = (k == 0); inValid = 1'b1; inData = s[k];
      tick();
      if (k == 0) begin
        checks++;
        if (stream_if.outValid !== 1'b0 || frameLenValid !== 1'b0) begin
          errors++;
          $display("FAIL tag_first_edge: valid=%b lenv=%b want 0/0", stream_if.outValid, frameLenValid);
        end
      end else begin
        checks++;
        if (stream_if.outValid !== 1'b1 || stream_if.outData !== s[k-1] || stream_if.outUser !== (k == 1)) begin
          errors++;
          $display("FAIL tag_out[%0d]: valid=%b data=%h user=%b want 1/%h/%b",
                   k-1, stream_if.outValid, stream_if.outData, stream_if.outUser, s[k-1], (k == 1));
        end
      end
    end
    syncTo10ms = 1'b0; inValid = 1'b0;
    tick();
    checks++;
    if (stream_if.outValid !== 1'b1 || stream_if.outData !== s[3] || stream_if.outUser !== 1'b0) begin
      errors++;
      $display("FAIL tag_out[3]: valid=%b data=%h user=%b want 1/%h/0", stream_if.outValid, stream_if.outData, stream_if.outUser, s[3]);
    end
    tick();
    checks++;
    if (stream_if.outValid !== 1'b0) begin
      errors++;
      $display("FAIL tag_drain: valid=%b want 0", stream_if.outValid);
    end
  endtask

  // Counter holds 4 from the previous frame, so the first sync here reports 4.
  task automatic test_frame_len();
    logic        exp_v;
    logic [15:0] exp_len;
    stream_if.outReady = 1'b1;
    for (int c = 0; c < 34; c++) begin
      syncTo10ms = ((c % 11) == 0); inValid = 1'b1; inData = 32'hC000_0000 + 32'(c);
      tick();
      exp_v   = ((c % 11) == 0);
      exp_len = (c == 0) ? 16'd4 : 16'd11;
      checks++;
      if (frameLenValid !== exp_v || (exp_v && frameLen !== exp_len)) begin
        errors++;
        $display("FAIL frame_len[%0d]: lenv=%b len=%0d want %b/%0d", c, frameLenValid, frameLen, exp_v, exp_len);
      end
    end
    syncTo10ms = 1'b0; inValid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (stream_if.outValid !== 1'b0) begin
      errors++;
      $display("FAIL frame_len_drain: valid=%b want 0", stream_if.outValid);
    end
  endtask

  task automatic test_overflow();
    stream_if.outReady = 1'b0;
    for (int k = 0; k < 20; k++) begin
      inValid = 1'b1; inData = 32'hA000_0000 + 32'(k);
      tick();
      checks++;
      if (overflow !== (k >= 17)) begin
        errors++;
        $display("FAIL ovf_flag[%0d]: got %b want %b", k, overflow, (k >= 17));
      end
      checks++;
      if (k == 0) begin
        if (stream_if.outValid !== 1'b0) begin
          errors++;
          $display("FAIL ovf_latency: valid=%b want 0", stream_if.outValid);
        end
      end else if (stream_if.outValid !== 1'b1 || stream_if.outData !== 32'hA000_0000) begin
        errors++;
        $display("FAIL ovf_stall[%0d]: valid=%b data=%h want 1/a0000000", k, stream_if.outValid, stream_if.outData);
      end
    end
    inValid = 1'b0;
    tick(); tick();
    stream_if.outReady = 1'b1;
    for (int j = 0; j < 17; j++) begin
      checks++;
      if (stream_if.outValid !== 1'b1 || stream_if.outData !== 32'hA000_0000 + 32'(j) || stream_if.outUser !== 1'b0) begin
        errors++;
        $display("FAIL ovf_drain[%0d]: valid=%b data=%h user=%b want 1/%h/0",
                 j, stream_if.outValid, stream_if.outData, stream_if.outUser, 32'hA000_0000 + 32'(j));
      end
      tick();
    end
    checks++;
    if (stream_if.outValid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_end: valid=%b ovf=%b want 0/1", stream_if.outValid, overflow);
    end
  endtask

  // Frame so far: 1 (sync sample) + 17 (overflow test) + 17 fill = 35.
  task automatic test_sync_drop();
    stream_if.outReady = 1'b0;
    for (int k = 0; k < 17; k++) begin
      inValid = 1'b1; inData = 32'hB000_0000 + 32'(k);
      tick();
    end
    syncTo10ms = 1'b1; inValid = 1'b1; inData = 32'hDEAD_0001;
    tick();
    checks++;
    if (frameLenValid !== 1'b1 || frameLen !== 16'd35) begin
      errors++;
      $display("FAIL drop_frame_len: lenv=%b len=%0d want 1/35", frameLenValid, frameLen);
    end
    // Push while full in the same edge as a pop: must be accepted and tagged.
    syncTo10ms = 1'b0; inValid = 1'b1; inData = 32'hBEEF_0002;
    stream_if.outReady = 1'b1;
    checks++;
    if (stream_if.outValid !== 1'b1 || stream_if.outData !== 32'hB000_0000) begin
      errors++;
      $display("FAIL drop_head: valid=%b data=%h want 1/b0000000", stream_if.outValid, stream_if.outData);
    end
    tick();
    inValid = 1'b0;
    for (int j = 1; j < 17; j++) begin
      checks++;
      if (stream_if.outValid !== 1'b1 || stream_if.outData !== 32'hB000_0000 + 32'(j) || stream_if.outUser !== 1'b0) begin
        errors++;
        $display("FAIL drop_drain[%0d]: valid=%b data=%h user=%b want 1/%h/0",
                 j, stream_if.outValid, stream_if.outData, stream_if.outUser, 32'hB000_0000 + 32'(j));
      end
      tick();
    end
    checks++;
    if (stream_if.outValid !== 1'b1 || stream_if.outData !== 32'hBEEF_0002 || stream_if.outUser !== 1'b1) begin
      errors++;
      $display("FAIL drop_tag_moved: valid=%b data=%h user=%b want 1/beef0002/1",
               stream_if.outValid, stream_if.outData, stream_if.outUser);
    end
    tick();
    checks++;
    if (stream_if.outValid !== 1'b0) begin
      errors++;
      $display("FAIL drop_end: valid=%b want 0", stream_if.outValid);
    end
  endtask

  task automatic test_reset_mid();
    stream_if.outReady = 1'b0;
    syncTo10ms = 1'b1; inValid = 1'b1; inData = 32'h1234_0000;
    tick();
    checks++;
    if (frameLenValid !== 1'b1 || frameLen !== 16'd1) begin
      errors++;
      $display("FAIL mid_frame_len: lenv=%b len=%0d want 1/1", frameLenValid, frameLen);
    end
    syncTo10ms = 1'b0; inData = 32'h1234_0001;
    tick();
    inValid = 1'b0;
    tick();
    checks++;
    if (stream_if.outValid !== 1'b1 || stream_if.outData !== 32'h1234_0000 || stream_if.outUser !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: valid=%b data=%h user=%b want 1/12340000/1", stream_if.outValid, stream_if.outData, stream_if.outUser);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (stream_if.outValid !== 1'b0 || stream_if.outUser !== 1'b0 || stream_if.outData !== 32'h0 ||
        overflow !== 1'b0 || frameLen !== 16'h0 || frameLenValid !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_clear: valid=%b user=%b data=%h ovf=%b len=%0d lenv=%b want all 0",
               stream_if.outValid, stream_if.outUser, stream_if.outData, overflow, frameLen, frameLenValid);
    end
    #1 rst = 1'b0;
    stream_if.outReady = 1'b1;
    inValid = 1'b1; inData = 32'h5555_0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (stream_if.outValid !== 1'b0) begin
        errors++;
        $display("FAIL mid_wait_sync[%0d]: valid=%b want 0", k, stream_if.outValid);
      end
    end
    syncTo10ms = 1'b1; inData = 32'hCAFE_0001;
    tick();
    checks++;
    if (frameLenValid !== 1'b0) begin
      errors++;
      $display("FAIL mid_first_sync_len: lenv=%b want 0", frameLenValid);
    end
    syncTo10ms = 1'b0; inValid = 1'b0;
    tick();
    checks++;
    if (stream_if.outValid !== 1'b1 || stream_if.outData !== 32'hCAFE_0001 || stream_if.outUser !== 1'b1) begin
      errors++;
      $display("FAIL mid_resync: valid=%b data=%h user=%b want 1/cafe0001/1", stream_if.outValid, stream_if.outData, stream_if.outUser);
    end
  endtask

  initial begin
    test_reset();
    test_no_sync();
    test_tagging();
    test_frame_len();
    test_overflow();
    test_sync_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
